result_master_axi4: RTL and testbench



---
 rtl/result_master_pkg.sv | 20 ++
 rtl/result_master_ring_addr.sv | 52 +++++
 rtl/result_master_axi4.sv | 182 ++++++++++++++++++
 tb/tb_result_master_axi4.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_master_pkg.sv
// Shared types and constants for the CGRA result write master (AXI4).
package result_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] BRESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/result_master_ring_addr.sv
// Ring-buffer destination address: lower/upper/inc config, current write
// address and the start address of the next transaction-set slot.
module result_master_ring_addr #(
    parameter int ADDR_WIDTH = 32,
    parameter int STEP       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_en,
    input  logic                  lower_wr,
    input  logic                  upper_wr,
    input  logic                  inc_wr,
    input  logic [ADDR_WIDTH-1:0] cfg_data,
    input  logic                  inc_set,
    input  logic                  beat,
    output logic [ADDR_WIDTH-1:0] cur_addr
);

    logic [ADDR_WIDTH-1:0] lower, upper, inc, set_start;
    logic [ADDR_WIDTH-1:0] lower_n, inc_n, slot_end;
    logic                  cfg_hit;

    always_comb begin
        lower_n  = lower_wr ? cfg_data : lower;
        inc_n    = inc_wr ? cfg_data : inc;
        cfg_hit  = cfg_en && (lower_wr || upper_wr || inc_wr);
        // last byte of the slot after the one being entered
        slot_end = set_start + inc + inc - ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lower     <= '0;
            upper     <= '0;
            inc       <= '0;
            set_start <= '0;
            cur_addr  <= '0;
        end else if (cfg_hit) begin
            lower     <= lower_n;
            inc       <= inc_n;
            if (upper_wr) upper <= cfg_data;
            cur_addr  <= lower_n;
            set_start <= lower_n + inc_n;
        end else if (inc_set) begin
            cur_addr  <= set_start;
            set_start <= (slot_end <= upper) ? set_start + inc : lower;
        end else if (beat) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/result_master_axi4.sv
// CGRA result write master: streams result words as AXI4 INCR bursts.
// Optional macro RESULT_MASTER_ERR_CNT_EN adds a saturating BRESP error counter.
module result_master_axi4
    import result_master_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int HDR_WIDTH       = DATA_WIDTH
) (
    input  logic                    CGRA_CLK_I,
    input  logic                    RST_N_I,
    input  logic                    EN_I,
    input  logic                    DEST_LOWER_WREN_I,
    input  logic                    DEST_UPPER_WREN_I,
    input  logic                    DEST_INC_WREN_I,
    input  logic [ADDR_WIDTH-1:0]   DEST_DATA_I,
    input  logic                    START_I,
    input  logic                    START_HDR_I,
    input  logic [7:0]              START_LEN_I,
    input  logic                    INC_SET_I,
    input  logic [DATA_WIDTH-1:0]   DATA_I,
    input  logic [HDR_WIDTH-1:0]    HDR_DATA_I,
    output logic                    DATA_REQ_O,
    output logic                    BUSY_O,
    output logic                    FULL_O,
    output logic                    ERR_O,
    input  logic                    ERR_CLR_I,
`ifdef RESULT_MASTER_ERR_CNT_EN
    output logic [15:0]             ERR_CNT_O,
`endif
    output logic [ADDR_WIDTH-1:0]   AXI_AWADDR_O,
    output logic [7:0]              AXI_AWLEN_O,
    output logic [2:0]              AXI_AWSIZE_O,
    output logic [1:0]              AXI_AWBURST_O,
    output logic                    AXI_AWVALID_O,
    input  logic                    AXI_AWREADY_I,
    output logic [DATA_WIDTH-1:0]   AXI_WDATA_O,
    output logic [DATA_WIDTH/8-1:0] AXI_WSTRB_O,
    output logic                    AXI_WLAST_O,
    output logic                    AXI_WVALID_O,
    input  logic                    AXI_WREADY_I,
    input  logic [1:0]              AXI_BRESP_I,
    input  logic                    AXI_BVALID_I,
    output logic                    AXI_BREADY_O
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OUT_W  = 4;

    state_t                state;
    logic [7:0]            len;
    logic                  hdr;
    logic [8:0]            cnt;
    logic                  wdone;
    logic [OUT_W-1:0]      outstanding;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] hdr_ext;
    logic                  aw_hs, w_hs, b_hs, last_hs, hdr_beat, b_bad, b_orphan;

    always_comb begin
        aw_hs    = AXI_AWVALID_O && AXI_AWREADY_I;
        w_hs     = AXI_WVALID_O && AXI_WREADY_I;
        b_hs     = AXI_BVALID_I && AXI_BREADY_O;
        hdr_beat = hdr && (cnt == 9'd0);
        last_hs  = w_hs && (cnt == {1'b0, len});
        b_bad    = b_hs && (AXI_BRESP_I != BRESP_OKAY);
        b_orphan = b_hs && !aw_hs && (outstanding == '0);
        hdr_ext  = '0;
        hdr_ext[HDR_WIDTH-1:0] = HDR_DATA_I;
    end

    assign AXI_AWSIZE_O  = 3'(clog2(STRB_W));
    assign AXI_AWBURST_O = BURST_INCR;
    assign AXI_WDATA_O   = !AXI_WVALID_O ? '0 : (hdr_beat ? hdr_ext : DATA_I);
    assign AXI_WSTRB_O   = {STRB_W{AXI_WVALID_O}};
    assign AXI_WLAST_O   = AXI_WVALID_O && (cnt == {1'b0, len});
    assign DATA_REQ_O    = w_hs && !hdr_beat;
    assign BUSY_O        = (state != ST_IDLE);
    assign FULL_O        = (outstanding == OUT_W'(MAX_OUTSTANDING));

    result_master_ring_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STEP       (STRB_W)
    ) u_ring (
        .clk      (CGRA_CLK_I),
        .rst_n    (RST_N_I),
        .cfg_en   (EN_I && (state == ST_IDLE)),
        .lower_wr (DEST_LOWER_WREN_I),
        .upper_wr (DEST_UPPER_WREN_I),
        .inc_wr   (DEST_INC_WREN_I),
        .cfg_data (DEST_DATA_I),
        .inc_set  (INC_SET_I),
        .beat     (w_hs),
        .cur_addr (cur_addr)
    );

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state         <= ST_IDLE;
            len           <= '0;
            hdr           <= 1'b0;
            cnt           <= '0;
            wdone         <= 1'b0;
            AXI_AWVALID_O <= 1'b0;
            AXI_AWADDR_O  <= '0;
            AXI_AWLEN_O   <= '0;
            AXI_WVALID_O  <= 1'b0;
            AXI_BREADY_O  <= 1'b0;
        end else begin
            AXI_BREADY_O <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (START_I && !FULL_O) begin
                        len           <= START_LEN_I;
                        hdr           <= START_HDR_I;
                        cnt           <= '0;
                        wdone         <= 1'b0;
                        AXI_AWVALID_O <= 1'b1;
                        AXI_AWADDR_O  <= cur_addr;
                        AXI_AWLEN_O   <= START_LEN_I;
                        // header beat may go out before the AW handshake
                        AXI_WVALID_O  <= START_HDR_I && EN_I;
                        state         <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (w_hs)    cnt   <= cnt + 9'd1;
                    if (last_hs) wdone <= 1'b1;
                    if (state == ST_ADDR) begin
                        if (aw_hs) begin
                            AXI_AWVALID_O <= 1'b0;
                            state         <= (wdone || last_hs) ? ST_IDLE : ST_DATA;
                        end
                    end else if (last_hs) begin
                        state <= ST_IDLE;
                    end
                    // WVALID only drops after a handshake
                    if (AXI_WVALID_O && !w_hs)
                        AXI_WVALID_O <= 1'b1;
                    else if (last_hs || wdone)
                        AXI_WVALID_O <= 1'b0;
                    else if (state == ST_DATA || aw_hs)
                        AXI_WVALID_O <= EN_I;
                    else if (hdr && cnt == 9'd0 && !w_hs)
                        AXI_WVALID_O <= EN_I;
                    else
                        AXI_WVALID_O <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            outstanding <= '0;
            ERR_O       <= 1'b0;
        end else begin
            if (aw_hs && !b_hs)
                outstanding <= outstanding + OUT_W'(1);
            else if (b_hs && !aw_hs && outstanding != '0)
                outstanding <= outstanding - OUT_W'(1);
            if (b_bad || b_orphan)
                ERR_O <= 1'b1;
            else if (ERR_CLR_I)
                ERR_O <= 1'b0;
        end
    end

`ifdef RESULT_MASTER_ERR_CNT_EN
    always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
        if (!RST_N_I)
            ERR_CNT_O <= '0;
        else if (ERR_CLR_I)
            ERR_CNT_O <= b_bad ? 16'd1 : 16'd0;
        else if (b_bad && ERR_CNT_O != 16'hFFFF)
            ERR_CNT_O <= ERR_CNT_O + 16'd1;
    end
`endif

endmodule

// File: tb/tb_result_master_axi4.sv
// Directed bench for result_master_axi4: bursts, header beat, ring wrap,
// outstanding limit, EN stalls, BRESP errors and async reset.
module tb_result_master_axi4;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, lower_wr, upper_wr, inc_wr, start, start_hdr, inc_set, err_clr;
    logic [AW-1:0] dest_data;
    logic [7:0]    start_len;
    logic [DW-1:0] data_in, hdr_data;
    logic          data_req, busy, full, err;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst, bresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
`ifdef RESULT_MASTER_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    always #5 clk = ~clk;

    result_master_axi4 dut (
        .CGRA_CLK_I(clk), .RST_N_I(rst_n), .EN_I(en),
        .DEST_LOWER_WREN_I(lower_wr), .DEST_UPPER_WREN_I(upper_wr),
        .DEST_INC_WREN_I(inc_wr), .DEST_DATA_I(dest_data),
        .START_I(start), .START_HDR_I(start_hdr), .START_LEN_I(start_len),
        .INC_SET_I(inc_set), .DATA_I(data_in), .HDR_DATA_I(hdr_data),
        .DATA_REQ_O(data_req), .BUSY_O(busy), .FULL_O(full), .ERR_O(err),
        .ERR_CLR_I(err_clr),
`ifdef RESULT_MASTER_ERR_CNT_EN
        .ERR_CNT_O(err_cnt),
`endif
        .AXI_AWADDR_O(awaddr), .AXI_AWLEN_O(awlen), .AXI_AWSIZE_O(awsize),
        .AXI_AWBURST_O(awburst), .AXI_AWVALID_O(awvalid), .AXI_AWREADY_I(awready),
        .AXI_WDATA_O(wdata), .AXI_WSTRB_O(wstrb), .AXI_WLAST_O(wlast),
        .AXI_WVALID_O(wvalid), .AXI_WREADY_I(wready),
        .AXI_BRESP_I(bresp), .AXI_BVALID_I(bvalid), .AXI_BREADY_O(bready)
    );

    // payload source: word index advances when the master consumes a beat
    logic [31:0] req_cnt;
    assign data_in = {32'hD0D0D0D0, req_cnt};
    always @(posedge clk or negedge rst_n)
        if (!rst_n) req_cnt <= '0;
        else if (data_req) req_cnt <= req_cnt + 32'd1;

    logic [DW-1:0] q_wdata[$];
    bit            q_wlast[$];
    logic [AW-1:0] q_awaddr[$];
    logic [7:0]    q_awlen[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid && awready) begin
                q_awaddr.push_back(awaddr);
                q_awlen.push_back(awlen);
            end
            if (wvalid && wready) begin
                q_wdata.push_back(wdata);
                q_wlast.push_back(wlast);
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dword(input logic [31:0] idx);
        return {32'hD0D0D0D0, idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [AW-1:0] lo, input logic [AW-1:0] up, input logic [AW-1:0] step);
        en = 1'b1;
        dest_data = lo;   lower_wr = 1'b1; tick(); lower_wr = 1'b0;
        dest_data = up;   upper_wr = 1'b1; tick(); upper_wr = 1'b0;
        dest_data = step; inc_wr   = 1'b1; tick(); inc_wr   = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] l, input logic h);
        start = 1'b1; start_len = l; start_hdr = h;
        tick();
        start = 1'b0; start_hdr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic send_b(input logic [1:0] r);
        bvalid = 1'b1; bresp = r;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic check_burst(input string tag, input int ab, input int wb, input logic [AW-1:0] addr,
                               input int beats, input logic [31:0] r0, input logic h);
        logic [31:0] lv;
        logic [63:0] got, exp;
        chk({tag, "_aw_cnt"}, 64'(q_awaddr.size() - ab), 64'd1);
        chk({tag, "_awaddr"}, (ab < q_awaddr.size()) ? 64'(q_awaddr[ab]) : '1, 64'(addr));
        chk({tag, "_awlen"}, (ab < q_awlen.size()) ? 64'(q_awlen[ab]) : '1, 64'(beats - 1));
        chk({tag, "_beats"}, 64'(q_wdata.size() - wb), 64'(beats));
        chk({tag, "_req"}, 64'(req_cnt - r0), 64'(h ? beats - 1 : beats));
        lv = '0;
        for (int k = 0; k < beats; k++) begin
            got = (wb + k < q_wdata.size()) ? q_wdata[wb + k] : '1;
            if (h && k == 0) exp = 64'hA5;
            else exp = dword(r0 + 32'(h ? k - 1 : k));
            chk({tag, "_wdata"}, got, exp);
            if (wb + k < q_wlast.size()) lv[k] = q_wlast[wb + k];
        end
        chk({tag, "_wlast"}, 64'(lv), 64'(32'd1 << (beats - 1)));
    endtask

    int ab, wb, n1;
    logic [31:0] r0;
    logic [AW-1:0] exp_slot [4] = '{32'h1040, 32'h1080, 32'h10C0, 32'h1000};

    initial begin
        rst_n = 1'b0; en = 1'b0; lower_wr = 1'b0; upper_wr = 1'b0; inc_wr = 1'b0;
        dest_data = '0; start = 1'b0; start_hdr = 1'b0; start_len = '0; inc_set = 1'b0;
        hdr_data = 64'hA5; err_clr = 1'b0; awready = 1'b1; wready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00;
        #12;
        chk("rst_outs", {awvalid, wvalid, wlast, data_req, busy, full, err, bready},
            8'd0);
        chk("rst_awsize", 64'(awsize), 64'd3);
        chk("rst_awburst", 64'(awburst), 64'd1);
        tick(); rst_n = 1'b1; tick();
        chk("bready_tied", 64'(bready), 64'd1);

        // basic 4-beat burst, no header
        cfg(32'h1000, 32'h10FF, 32'h40);
        ab = q_awaddr.size(); wb = q_wdata.size(); r0 = req_cnt;
        start_burst(8'd3, 1'b0); wait_idle("t1_idle");
        check_burst("t1", ab, wb, 32'h1000, 4, r0, 1'b0);
        send_b(2'b00);

        // header beat first; address continues after 4 beats of 8 bytes
        ab = q_awaddr.size(); wb = q_wdata.size(); r0 = req_cnt;
        start_burst(8'd2, 1'b1); wait_idle("t2_idle");
        check_burst("t2", ab, wb, 32'h1020, 3, r0, 1'b1);
        send_b(2'b00);

        // transaction-set slots and wrap
        cfg(32'h1000, 32'h10FF, 32'h40);
        for (int i = 0; i < 4; i++) begin
            inc_set = 1'b1; tick(); inc_set = 1'b0;
            ab = q_awaddr.size();
            start_burst(8'd0, 1'b0); wait_idle("t3_idle");
            chk("t3_slot_addr", (ab < q_awaddr.size()) ? 64'(q_awaddr[ab]) : '1, 64'(exp_slot[i]));
            send_b(2'b00);
        end

        // outstanding limit with B withheld
        for (int i = 0; i < 4; i++) begin
            start_burst(8'd0, 1'b0); wait_idle("t4_idle");
            chk("t4_full", 64'(full), 64'(i == 3));
        end
        ab = q_awaddr.size();
        start_burst(8'd0, 1'b0); tick();
        chk("t4_ignored_busy", 64'(busy), 64'd0);
        chk("t4_ignored_aw", 64'(q_awaddr.size() - ab), 64'd0);
        send_b(2'b00);
        chk("t4_slot_freed", 64'(full), 64'd0);
        for (int i = 0; i < 3; i++) send_b(2'b00);
        chk("t4_err_clean", 64'(err), 64'd0);

        // EN stall mid-burst
        cfg(32'h1000, 32'h10FF, 32'h40);
        ab = q_awaddr.size(); wb = q_wdata.size(); r0 = req_cnt;
        start_burst(8'd7, 1'b0);
        n1 = 0;
        while (q_wdata.size() - wb < 2 && n1 < 50) begin tick(); n1++; end
        en = 1'b0;
        tick(); tick();
        n1 = q_wdata.size();
        chk("t5_wvalid_low", 64'(wvalid), 64'd0);
        tick(); tick(); tick();
        chk("t5_no_beats_stalled", 64'(q_wdata.size()), 64'(n1));
        en = 1'b1;
        wait_idle("t5_idle");
        check_burst("t5", ab, wb, 32'h1000, 8, r0, 1'b0);
        send_b(2'b00);
        ab = q_awaddr.size();
        start_burst(8'd0, 1'b0); wait_idle("t5b_idle");
        chk("t5_next_addr", (ab < q_awaddr.size()) ? 64'(q_awaddr[ab]) : '1, 64'h1040);

        // BRESP error, clear, orphan B, clear-vs-new-error
        send_b(2'b10);
        chk("t6_err_set", 64'(err), 64'd1);
`ifdef RESULT_MASTER_ERR_CNT_EN
        chk("t6_err_cnt", 64'(err_cnt), 64'd1);
`endif
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t6_err_clr", 64'(err), 64'd0);
        send_b(2'b00);
        chk("t6_orphan_b", 64'(err), 64'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        start_burst(8'd0, 1'b0); wait_idle("t6_idle");
        err_clr = 1'b1; send_b(2'b10); err_clr = 1'b0;
        chk("t6_clr_vs_new", 64'(err), 64'd1);
`ifdef RESULT_MASTER_ERR_CNT_EN
        chk("t6_cnt_clr_new", 64'(err_cnt), 64'd1);
`endif

        // async reset mid-burst
        wready = 1'b0;
        start_burst(8'd7, 1'b0); tick(); tick();
        chk("t6_mid_burst", 64'({busy, wvalid}), 64'b11);
        rst_n = 1'b0; #1;
        chk("t6_async_rst", {awvalid, wvalid, wlast, data_req, busy, full, err, bready,
                             |wdata, |awaddr, |awlen, |wstrb}, 12'd0);
        tick(); rst_n = 1'b1; wready = 1'b1; tick();
        chk("t6_post_rst_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
